// File: rtl/wb_rom_arb2.sv
// Round-robin two-master Wishbone arbiter for one shared slave, holding each grant
// for the owner's whole CYC and aborting unacknowledged strobes with a watchdog ERR.
module wb_rom_arb2 #(
    parameter int WB_ADDRESS_WIDTH = 32,
    parameter int WB_DATA_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                          clk,
    input  logic                          rstn,
    // requester 0
    input  logic [WB_ADDRESS_WIDTH-1:0]   m0_adr_i,
    input  logic [WB_DATA_WIDTH-1:0]      m0_dat_w_i,
    output logic [WB_DATA_WIDTH-1:0]      m0_dat_r_o,
    input  logic                          m0_cyc_i,
    input  logic                          m0_stb_i,
    input  logic                          m0_we_i,
    input  logic [WB_DATA_WIDTH/8-1:0]    m0_sel_i,
    output logic                          m0_ack_o,
    output logic                          m0_err_o,
    // requester 1
    input  logic [WB_ADDRESS_WIDTH-1:0]   m1_adr_i,
    input  logic [WB_DATA_WIDTH-1:0]      m1_dat_w_i,
    output logic [WB_DATA_WIDTH-1:0]      m1_dat_r_o,
    input  logic                          m1_cyc_i,
    input  logic                          m1_stb_i,
    input  logic                          m1_we_i,
    input  logic [WB_DATA_WIDTH/8-1:0]    m1_sel_i,
    output logic                          m1_ack_o,
    output logic                          m1_err_o,
    // shared slave
    output logic [WB_ADDRESS_WIDTH-1:0]   s_adr_o,
    output logic [WB_DATA_WIDTH-1:0]      s_dat_w_o,
    input  logic [WB_DATA_WIDTH-1:0]      s_dat_r_i,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic                          s_we_o,
    output logic [WB_DATA_WIDTH/8-1:0]    s_sel_o,
    input  logic                          s_ack_i,
    input  logic                          s_err_i,
    // status
    output logic [1:0]                    grant,
    output logic                          timeout
);

    typedef enum logic [1:0] {IDLE, G0, G1, TURN} state_t;

    localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;      // 1: m1 was granted most recently
    logic [15:0] wd_q, wd_d;
    logic        timeout_q;
    logic        stb_block_q;         // masks STB for one cycle after an abort
    logic        expire;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            wd_q        <= '0;
            timeout_q   <= 1'b0;
            stb_block_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            wd_q        <= wd_d;
            timeout_q   <= expire;
            stb_block_q <= expire;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = G0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = G1;
                    last_d  = 1'b1;
                end
            end
            G0:      if (!m0_cyc_i) state_d = TURN;
            G1:      if (!m1_cyc_i) state_d = TURN;
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Slave-side request mux: everything is zero outside G0/G1.
    always_comb begin
        s_adr_o   = '0;
        s_dat_w_o = '0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        case (state_q)
            G0: begin
                s_adr_o   = m0_adr_i;
                s_dat_w_o = m0_dat_w_i;
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = m0_stb_i & ~stb_block_q;
                s_we_o    = m0_we_i;
                s_sel_o   = m0_sel_i;
            end
            G1: begin
                s_adr_o   = m1_adr_i;
                s_dat_w_o = m1_dat_w_i;
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = m1_stb_i & ~stb_block_q;
                s_we_o    = m1_we_i;
                s_sel_o   = m1_sel_i;
            end
            default: ;
        endcase
    end

    // A slave ACK in the expiry cycle wins over the watchdog.
    assign expire = WD_EN && s_cyc_o && s_stb_o && (wd_q == WD_LAST) && !s_ack_i;

    always_comb begin
        if (!s_stb_o || s_ack_i || s_err_i || expire) begin
            wd_d = '0;
        end else if (s_cyc_o) begin
            wd_d = wd_q + 16'd1;
        end else begin
            wd_d = wd_q;
        end
    end

    always_comb begin
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            G0: begin
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | expire;
            end
            G1: begin
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | expire;
            end
            default: ;
        endcase
    end

    assign m0_dat_r_o = s_dat_r_i;
    assign m1_dat_r_o = s_dat_r_i;
    assign grant      = {state_q == G1, state_q == G0};
    assign timeout    = timeout_q;

endmodule
